// File: rtl/bus_bridge_pkg.sv
// Shared definitions for the multi-channel system bus bridge.
//   - state_e          : bridge FSM encoding (IDLE, ACCESS, RESP, ERR_RESP)
//   - DATA_W           : bus data/address width
//   - *_LO / *_HI      : default address map (DM, TIMER0, TIMER1, INT)
//   - DEF_SLV_LO/HI    : default map flattened, slot k = bits [32k+31:32k]
//   - in_window()      : inclusive unsigned window compare
package bus_bridge_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RESP     = 2'd2,
    ERR_RESP = 2'd3
  } state_e;

  localparam logic [DATA_W-1:0] DM_LO     = 32'h0000_0000;
  localparam logic [DATA_W-1:0] DM_HI     = 32'h0000_2fff;
  localparam logic [DATA_W-1:0] TIMER0_LO = 32'h0000_7f00;
  localparam logic [DATA_W-1:0] TIMER0_HI = 32'h0000_7f0b;
  localparam logic [DATA_W-1:0] TIMER1_LO = 32'h0000_7f10;
  localparam logic [DATA_W-1:0] TIMER1_HI = 32'h0000_7f1b;
  localparam logic [DATA_W-1:0] INT_LO    = 32'h0000_7f20;
  localparam logic [DATA_W-1:0] INT_HI    = 32'h0000_7f23;

  localparam logic [4*DATA_W-1:0] DEF_SLV_LO = {INT_LO, TIMER1_LO, TIMER0_LO, DM_LO};
  localparam logic [4*DATA_W-1:0] DEF_SLV_HI = {INT_HI, TIMER1_HI, TIMER0_HI, DM_HI};

  function automatic logic in_window(logic [DATA_W-1:0] a,
                                     logic [DATA_W-1:0] lo,
                                     logic [DATA_W-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/bus_bridge_mc_if.sv
// Bus bundle between the CPU memory stage, the bridge and its slaves.
//   CPU side  : cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byteen -> bridge
//               cpu_ready, cpu_rdata, cpu_err                    <- bridge
//   Slave side: slv_sel, slv_we, slv_addr, slv_wdata, slv_byteen <- bridge
//               slv_rdata (flattened NUM_SLV*32), slv_ack        -> bridge
// Modports:
//   master : the environment (CPU plus attached slaves)
//   slave  : the bridge itself
interface bus_bridge_mc_if #(parameter int NUM_SLV = 4);
  import bus_bridge_pkg::*;

  logic                      cpu_req;
  logic                      cpu_we;
  logic [DATA_W-1:0]         cpu_addr;
  logic [DATA_W-1:0]         cpu_wdata;
  logic [3:0]                cpu_byteen;
  logic                      cpu_ready;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_err;

  logic [NUM_SLV-1:0]        slv_sel;
  logic                      slv_we;
  logic [DATA_W-1:0]         slv_addr;
  logic [DATA_W-1:0]         slv_wdata;
  logic [3:0]                slv_byteen;
  logic [NUM_SLV*DATA_W-1:0] slv_rdata;
  logic [NUM_SLV-1:0]        slv_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byteen,
    input  cpu_ready, cpu_rdata, cpu_err,
    input  slv_sel, slv_we, slv_addr, slv_wdata, slv_byteen,
    output slv_rdata, slv_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byteen,
    output cpu_ready, cpu_rdata, cpu_err,
    output slv_sel, slv_we, slv_addr, slv_wdata, slv_byteen,
    input  slv_rdata, slv_ack
  );

endinterface

// File: rtl/bus_bridge_mc_addr_decoder.sv
// Combinational address decoder for the bus bridge.
//   addr_i : byte address to decode
//   hit_o  : one-hot slot hit; on overlapping windows the lowest slot wins
//   miss_o : no window matched
// Windows are given by parameters SLV_LO/SLV_HI, inclusive, unsigned.
module addr_decoder
  import bus_bridge_pkg::*;
#(
  parameter int                        NUM_SLV = 4,
  parameter logic [NUM_SLV*DATA_W-1:0] SLV_LO  = DEF_SLV_LO,
  parameter logic [NUM_SLV*DATA_W-1:0] SLV_HI  = DEF_SLV_HI
) (
  input  logic [DATA_W-1:0]  addr_i,
  output logic [NUM_SLV-1:0] hit_o,
  output logic               miss_o
);

  always_comb begin
    hit_o = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if ((hit_o == '0) &&
          in_window(addr_i, SLV_LO[DATA_W*k +: DATA_W], SLV_HI[DATA_W*k +: DATA_W]))
        hit_o[k] = 1'b1;
    end
  end

  assign miss_o = ~|hit_o;

endmodule

// File: rtl/bus_bridge_mc.sv
// Multi-channel system bus bridge: CPU memory stage to NUM_SLV slaves.
// One transaction at a time; decode in IDLE, wait for the selected slave's
// ack in ACCESS, return a registered one-cycle response.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : bus_bridge_mc_if.slave (CPU request/response, slave bus)
// Optional (macro BUS_BRIDGE_ERR_LOG_EN):
//   err_clr  : one-cycle pulse clears the error log
//   err_addr : address of the most recent bus error
//   err_cnt  : number of bus errors, saturating at 255
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for cpu_req; decode and latch request
// ACCESS   | slv_sel held, waiting for selected ack or timeout
// RESP     | cpu_ready pulse, data valid, no error
// ERR_RESP | cpu_ready pulse with cpu_err (unmapped or timed out)
module bus_bridge_mc
  import bus_bridge_pkg::*;
#(
  parameter int                        NUM_SLV = 4,
  parameter logic [NUM_SLV*DATA_W-1:0] SLV_LO  = DEF_SLV_LO,
  parameter logic [NUM_SLV*DATA_W-1:0] SLV_HI  = DEF_SLV_HI,
  parameter int                        TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  bus_bridge_mc_if.slave   bus
`ifdef BUS_BRIDGE_ERR_LOG_EN
  ,
  input  logic             err_clr,
  output logic [DATA_W-1:0] err_addr,
  output logic [7:0]       err_cnt
`endif
);

  // At least one bit so TIMEOUT=0 still elaborates; the counter is then unused.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_SLV-1:0] sel_q;
  logic               we_q;
  logic [DATA_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [3:0]         be_q;
  logic               ready_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;

  logic [NUM_SLV-1:0] dec_hit;
  logic               dec_miss;
  logic               sel_ack;
  logic [DATA_W-1:0]  sel_rdata;
  logic               timeout_hit;

  addr_decoder #(
    .NUM_SLV (NUM_SLV),
    .SLV_LO  (SLV_LO),
    .SLV_HI  (SLV_HI)
  ) u_dec (
    .addr_i (bus.cpu_addr),
    .hit_o  (dec_hit),
    .miss_o (dec_miss)
  );

  // Acks from slaves that are not selected are masked off.
  assign sel_ack     = |(bus.slv_ack & sel_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (sel_q[k])
        sel_rdata = bus.slv_rdata[DATA_W*k +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses.
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cpu_req) begin
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            be_q    <= bus.cpu_we ? bus.cpu_byteen : 4'h0;
            cnt_q   <= '0;
            if (dec_miss) begin
              state_q <= ERR_RESP;
              we_q    <= 1'b0;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= ACCESS;
              we_q    <= bus.cpu_we;
              sel_q   <= dec_hit;
            end
          end
        end
        ACCESS: begin
          if (sel_ack) begin
            state_q <= RESP;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            rdata_q <= we_q ? '0 : sel_rdata;
          end else if (timeout_hit) begin
            state_q <= ERR_RESP;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:     state_q <= IDLE;
        ERR_RESP: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ready  = ready_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_err    = err_q;
  assign bus.slv_sel    = sel_q;
  assign bus.slv_we     = we_q;
  assign bus.slv_addr   = addr_q;
  assign bus.slv_wdata  = wdata_q;
  assign bus.slv_byteen = be_q;

`ifdef BUS_BRIDGE_ERR_LOG_EN
  logic               err_event;
  logic [DATA_W-1:0]  err_event_addr;
  logic [DATA_W-1:0]  err_addr_q;
  logic [7:0]         err_cnt_q;

  // Logged on the edge that enters ERR_RESP so the log is current during
  // the error response cycle.
  assign err_event = ((state_q == IDLE) && bus.cpu_req && dec_miss) ||
                     ((state_q == ACCESS) && !sel_ack && timeout_hit);
  assign err_event_addr = (state_q == IDLE) ? bus.cpu_addr : addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else if (err_event) begin
      err_addr_q <= err_event_addr;
      if (err_clr)
        err_cnt_q <= 8'd1;
      else if (err_cnt_q != 8'hff)
        err_cnt_q <= err_cnt_q + 8'd1;
    end else if (err_clr) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end
  end

  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_bus_bridge_mc.sv
module tb_bus_bridge_mc;
  import bus_bridge_pkg::*;

  localparam int NUM_SLV = 4;
  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 4096;
  localparam int NEVER   = 1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bus_bridge_mc_if #(.NUM_SLV(NUM_SLV)) bus ();

`ifdef BUS_BRIDGE_ERR_LOG_EN
  logic        err_clr = 1'b0;
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;
  int          m_err_cnt = 0;
  logic [31:0] m_err_addr = '0;
`endif

  bus_bridge_mc #(.NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef BUS_BRIDGE_ERR_LOG_EN
    ,
    .err_clr  (err_clr),
    .err_addr (err_addr),
    .err_cnt  (err_cnt)
`endif
  );

  // Address map as the CPU sees it
  logic [31:0] win_lo [4] = '{32'h0000, 32'h7f00, 32'h7f10, 32'h7f20};
  logic [31:0] win_hi [4] = '{32'h2fff, 32'h7f0b, 32'h7f1b, 32'h7f23};

  function automatic int decode(logic [31:0] a);
    for (int k = 0; k < 4; k++)
      if (a >= win_lo[k] && a <= win_hi[k]) return k;
    return -1;
  endfunction

  // Expected per-cycle outputs, indexed by cycle number
  bit          e_ready [DEPTH];
  bit          e_err   [DEPTH];
  logic [31:0] e_rdata [DEPTH];
  logic [3:0]  e_sel   [DEPTH];
  bit          e_we    [DEPTH];
  logic [31:0] e_addr  [DEPTH];
  logic [31:0] e_wdata [DEPTH];
  logic [3:0]  e_be    [DEPTH];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave models: selected slave acks after cur_delay extra ACCESS cycles;
  // unselected slaves may assert spurious acks.
  int         acc_cnt = 0;
  int         cur_delay = 0;
  bit         noise_en = 1'b0;
  logic [3:0] noise_fix = 4'h0;
  logic [3:0] noise = 4'h0;

  always @(posedge clk) acc_cnt <= (bus.slv_sel != '0) ? acc_cnt + 1 : 0;
  always @(posedge clk) begin
    #2;
    noise = noise_en ? 4'($urandom) : noise_fix;
  end
  assign bus.slv_ack = (bus.slv_sel & {4{acc_cnt == cur_delay}}) | (noise & ~bus.slv_sel);

  always @(negedge clk) begin
    if (chk_en && reset_n && cyc < DEPTH) begin
      chk("cpu_ready", 32'(bus.cpu_ready), 32'(e_ready[cyc]));
      chk("cpu_err",   32'(bus.cpu_err),   32'(e_err[cyc]));
      chk("cpu_rdata", bus.cpu_rdata, e_rdata[cyc]);
      chk("slv_sel",   32'(bus.slv_sel),   32'(e_sel[cyc]));
      if (e_sel[cyc] != '0) begin
        chk("slv_we",     32'(bus.slv_we),     32'(e_we[cyc]));
        chk("slv_addr",   bus.slv_addr,        e_addr[cyc]);
        chk("slv_wdata",  bus.slv_wdata,       e_wdata[cyc]);
        chk("slv_byteen", 32'(bus.slv_byteen), 32'(e_be[cyc]));
      end
    end
  end

  task automatic clear_exp(input int from, input int to);
    for (int i = from; i <= to && i < DEPTH; i++) begin
      e_ready[i] = 0; e_err[i] = 0; e_rdata[i] = '0; e_sel[i] = '0;
      e_we[i] = 0; e_addr[i] = '0; e_wdata[i] = '0; e_be[i] = '0;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a request in the current cycle and predict its timeline.
  task automatic start_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int delay, input logic [31:0] rd,
                           output int rc);
    int c;
    int k;
    int n;
    logic [127:0] v;
    c = cyc;
    k = decode(addr);
    for (int j = 0; j < 4; j++) v[32*j +: 32] = $urandom;
    if (k >= 0) v[32*k +: 32] = rd;
    bus.slv_rdata  = v;
    cur_delay      = delay;
    bus.cpu_req    = 1'b1;
    bus.cpu_we     = we;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = wdata;
    bus.cpu_byteen = be;
    if (k < 0) begin
      rc = c + 1;
      e_ready[rc] = 1; e_err[rc] = 1;
    end else begin
      n = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
      for (int i = 1; i <= n; i++) begin
        e_sel[c+i] = 4'(1 << k); e_we[c+i] = we; e_addr[c+i] = addr;
        e_wdata[c+i] = wdata; e_be[c+i] = we ? be : 4'h0;
      end
      rc = c + n + 1;
      e_ready[rc] = 1;
      if (delay < TIMEOUT) e_rdata[rc] = we ? 32'h0 : rd;
      else e_err[rc] = 1;
    end
`ifdef BUS_BRIDGE_ERR_LOG_EN
    if (e_err[rc]) begin
      m_err_cnt  = (m_err_cnt == 255) ? 255 : m_err_cnt + 1;
      m_err_addr = addr;
    end
`endif
  endtask

  task automatic finish_txn(input int rc);
    wait_cyc(rc);
`ifdef BUS_BRIDGE_ERR_LOG_EN
    if (e_err[rc]) begin
      chk("err_cnt",  32'(err_cnt), 32'(m_err_cnt));
      chk("err_addr", err_addr, m_err_addr);
    end
`endif
    wait_cyc(rc + 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.cpu_ready), 32'h0);
    chk({tag, "_err"},   32'(bus.cpu_err),   32'h0);
    chk({tag, "_rdata"}, bus.cpu_rdata,      32'h0);
    chk({tag, "_sel"},   32'(bus.slv_sel),   32'h0);
    chk({tag, "_we"},    32'(bus.slv_we),    32'h0);
    chk({tag, "_addr"},  bus.slv_addr,       32'h0);
    chk({tag, "_wdata"}, bus.slv_wdata,      32'h0);
    chk({tag, "_be"},    32'(bus.slv_byteen), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    int rc;
    int rc2;
    int k;
    int sel;
    int r;
    int dly;
    logic [31:0] a;

    clear_exp(0, DEPTH - 1);
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0;
    bus.cpu_wdata = '0; bus.cpu_byteen = '0; bus.slv_rdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    reset_n = 1'b1;
    chk_en = 1'b1;
    wait_cyc(cyc + 2);

    // DM read, same-cycle ack
    c = cyc;
    start_txn(0, 32'h0000_1000, 32'h0, 4'hf, 0, 32'hDEADBEEF, rc);
    chk("dm_latency", 32'(rc - c), 32'd2);
    wait_cyc(c + 1);
    chk("dm_sel", 32'(bus.slv_sel), 32'h1);
    wait_cyc(rc);
    chk("dm_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    finish_txn(rc);
    bus.cpu_req = 0;
    wait_cyc(cyc + 2);

    // Timer1 write at upper boundary, ack in third ACCESS cycle
    c = cyc;
    start_txn(1, 32'h0000_7f1b, 32'h12345678, 4'hf, 2, 32'h5555AAAA, rc);
    chk("wr_latency", 32'(rc - c), 32'd4);
    wait_cyc(c + 3);
    chk("wr_sel", 32'(bus.slv_sel), 32'h4);
    chk("wr_wdata", bus.slv_wdata, 32'h12345678);
    wait_cyc(rc);
    chk("wr_rdata", bus.cpu_rdata, 32'h0);
    finish_txn(rc);
    bus.cpu_req = 0;
    wait_cyc(cyc + 1);

    // Unmapped gap between windows
    c = cyc;
    start_txn(0, 32'h0000_7f0c, 32'h0, 4'h0, 0, 32'h0, rc);
    chk("unm_latency", 32'(rc - c), 32'd1);
    wait_cyc(rc);
    chk("unm_err", 32'(bus.cpu_err), 32'h1);
    chk("unm_sel", 32'(bus.slv_sel), 32'h0);
    finish_txn(rc);
    bus.cpu_req = 0;
    wait_cyc(cyc + 1);

    // Timeout on never-acking INT slave
    c = cyc;
    start_txn(0, 32'h0000_7f20, 32'h0, 4'h0, NEVER, 32'h0, rc);
    chk("to_latency", 32'(rc - c), 32'd17);
    wait_cyc(c + 16);
    chk("to_sel_last", 32'(bus.slv_sel), 32'h8);
    wait_cyc(rc);
    chk("to_err", 32'(bus.cpu_err), 32'h1);
    chk("to_sel_off", 32'(bus.slv_sel), 32'h0);
    finish_txn(rc);
    bus.cpu_req = 0;
    wait_cyc(cyc + 1);

    // Ack on the last cycle before timeout wins
    c = cyc;
    start_txn(0, 32'h0000_7f23, 32'h0, 4'h0, 15, 32'h0BADF00D, rc);
    chk("late_latency", 32'(rc - c), 32'd17);
    wait_cyc(rc);
    chk("late_err", 32'(bus.cpu_err), 32'h0);
    chk("late_rdata", bus.cpu_rdata, 32'h0BADF00D);
    finish_txn(rc);
    bus.cpu_req = 0;
    wait_cyc(cyc + 1);

    // Reset in the middle of an access to TIMER0
    c = cyc;
    start_txn(0, 32'h0000_7f04, 32'h0, 4'h0, NEVER, 32'h0, rc);
    wait_cyc(c + 3);
    chk("mid_sel", 32'(bus.slv_sel), 32'h2);
    reset_n = 1'b0;
    bus.cpu_req = 0;
    #1;
    chk_all_zero("midrst");
    clear_exp(cyc, cyc + 40);
`ifdef BUS_BRIDGE_ERR_LOG_EN
    m_err_cnt = 0;
    m_err_addr = '0;
`endif
    wait_cyc(cyc + 3);
    reset_n = 1'b1;
    wait_cyc(cyc + 5);
    c = cyc;
    start_txn(0, 32'h0000_7f04, 32'h0, 4'h0, 1, 32'hCAFEF00D, rc);
    wait_cyc(rc);
    chk("post_rst_rdata", bus.cpu_rdata, 32'hCAFEF00D);
    finish_txn(rc);
    bus.cpu_req = 0;
    wait_cyc(cyc + 1);

    // Back-to-back with a stale ack from slave0 during the second access
    noise_fix = 4'b0001;
    start_txn(0, 32'h0000_0000, 32'h0, 4'h0, 0, 32'h11112222, rc);
    finish_txn(rc);
    c = cyc;
    start_txn(0, 32'h0000_7f10, 32'h0, 4'h0, 3, 32'h33334444, rc2);
    chk("b2b_latency", 32'(rc2 - rc), 32'd6);
    wait_cyc(c + 1);
    chk("b2b_sel", 32'(bus.slv_sel), 32'h4);
    wait_cyc(rc2);
    chk("b2b_rdata", bus.cpu_rdata, 32'h33334444);
    finish_txn(rc2);
    bus.cpu_req = 0;
    noise_fix = 4'b0000;
    wait_cyc(cyc + 1);

    // Randomized traffic
    noise_en = 1'b1;
    for (int t = 0; t < 150; t++) begin
      if (cyc > DEPTH - 60) break;
      k = $urandom_range(0, 3);
      sel = $urandom_range(0, 5);
      case (sel)
        0:       a = win_lo[k] + ($urandom % (win_hi[k] - win_lo[k] + 1));
        1:       a = win_lo[k];
        2:       a = win_hi[k];
        3:       a = win_hi[k] + 1;
        4:       a = win_lo[k] - 1;
        default: a = $urandom;
      endcase
      r = $urandom_range(0, 9);
      if (r < 7)       dly = $urandom_range(0, 5);
      else if (r == 7) dly = TIMEOUT - 1;
      else if (r == 8) dly = TIMEOUT;
      else             dly = NEVER;
      start_txn(1'($urandom), a, $urandom, 4'($urandom), dly, $urandom, rc);
      finish_txn(rc);
      if ($urandom_range(0, 1) == 0) begin
        bus.cpu_req = 0;
        wait_cyc(cyc + $urandom_range(0, 3));
      end
    end
    bus.cpu_req = 0;
    noise_en = 1'b0;
    wait_cyc(cyc + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
